// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises lock, releases sys_rst_n after stable lock, counts loss-of-lock events.
// Optional LED heartbeat in RUN when HEARTBEAT_EN is defined.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned HB_DIV        = 30000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock,
    input  logic             clear_count,
    output logic             sys_rst_n,
    output logic             loss_pulse,
    output logic [CNT_W-1:0] loss_count,
    output logic             heartbeat
);

    localparam int unsigned MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

    if (SYNC_STAGES < 2 || STABLE_CYCLES == 0 || HOLD_CYCLES == 0 || CNT_W == 0 || HB_DIV == 0) begin : g_param_check
        $error("pll_lock_supervisor: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_STAB,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   loss_c;

    // Lock synchroniser; only the last stage feeds the FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State and cycle counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_c  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = ST_STAB;
                end
            end
            ST_STAB: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    loss_c  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs; sys_rst_n follows the next state so it changes on the transition edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sys_rst_n  <= 1'b0;
            loss_pulse <= 1'b0;
            loss_count <= '0;
        end else begin
            sys_rst_n  <= (state_d == ST_RUN);
            loss_pulse <= loss_c;
            if (clear_count) begin
                loss_count <= loss_c ? CNT_W'(1) : '0;
            end else if (loss_c && (loss_count != LOSS_MAX)) begin
                loss_count <= loss_count + CNT_W'(1);
            end
        end
    end

`ifdef HEARTBEAT_EN
    localparam int unsigned HB_W = $clog2(HB_DIV) + 1;

    logic [HB_W-1:0] hb_cnt_q;

    // Heartbeat divider, only running while in RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt_q  <= '0;
            heartbeat <= 1'b0;
        end else if (state_d != ST_RUN) begin
            hb_cnt_q  <= '0;
            heartbeat <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (hb_cnt_q == HB_W'(HB_DIV - 1)) begin
                hb_cnt_q  <= '0;
                heartbeat <= ~heartbeat;
            end else begin
                hb_cnt_q <= hb_cnt_q + HB_W'(1);
            end
        end
    end
`else
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (SYNC=2, STABLE=16, HOLD=4, CNT_W=4, HB_DIV=5).
module tb_pll_lock_supervisor;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 16;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned CW     = 4;
    localparam int unsigned HBD    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lock;
    logic          clear_count;
    logic          sys_rst_n;
    logic          loss_pulse;
    logic [CW-1:0] loss_count;
    logic          heartbeat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    bit hb_seen = 1'b0;
    int e;
    int base;
    int cnt_after;

    pll_lock_supervisor #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .CNT_W        (CW),
        .HB_DIV       (HBD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lock       (lock),
        .clear_count(clear_count),
        .sys_rst_n  (sys_rst_n),
        .loss_pulse (loss_pulse),
        .loss_count (loss_count),
        .heartbeat  (heartbeat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (loss_pulse === 1'b1) pulses++;
        if (heartbeat !== 1'b0) hb_seen = 1'b1;
    endtask

    // Edge number of the first sys_rst_n=1 sample, or -1 if the budget expires
    task automatic wait_release(input int budget, output int edge_no);
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sys_rst_n === 1'b1) begin
                edge_no = cyc;
                break;
            end
        end
    endtask

    // Loss event from RUN; clear_count optionally coincides with the detecting edge
    task automatic loss_event(input bit with_clear, output int count_after);
        int rel;
        lock = 1'b0;
        tick();
        tick();
        clear_count = with_clear;
        tick();
        clear_count = 1'b0;
        count_after = int'(loss_count);
        lock = 1'b1;
        wait_release(60, rel);
        check("loss_event_rerelease", 32'(rel != -1), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        lock        = 1'b1;
        clear_count = 1'b0;
        tick();
        tick();
        check("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("reset_loss_pulse", 32'(loss_pulse), 32'd0);
        check("reset_loss_count", 32'(loss_count), 32'd0);
        check("reset_heartbeat", 32'(heartbeat), 32'd0);

        // Scenario 1: lock high from reset, release on edge 19
        rst_n = 1'b1;
        cyc   = 0;
        repeat (18) tick();
        check("s1_held_edge18", 32'(sys_rst_n), 32'd0);
        tick();
        check("s1_release_edge19", 32'(sys_rst_n), 32'd1);
        check("s1_loss_count", 32'(loss_count), 32'd0);

        // Scenario 2: lock drops mid-STAB (cnt=10), full restabilisation, release on edge 35
        rst_n = 1'b0;
        tick();
        check("s2_reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
        rst_n = 1'b1;
        cyc   = 0;
        repeat (13) tick();
        lock = 1'b0;
        repeat (3) tick();
        lock = 1'b1;
        wait_release(60, e);
        check("s2_release_edge", 32'(e), 32'd35);
        check("s2_no_pulse", 32'(pulses), 32'd0);
        check("s2_loss_count", 32'(loss_count), 32'd0);

        // Scenario 3: 2-cycle lock drop in RUN
        base = cyc;
        lock = 1'b0;
        tick();
        tick();
        check("s3_still_released", 32'(sys_rst_n), 32'd1);
        lock = 1'b1;
        tick();
        check("s3_reset_asserted", 32'(sys_rst_n), 32'd0);
        check("s3_pulse_high", 32'(loss_pulse), 32'd1);
        check("s3_loss_count", 32'(loss_count), 32'd1);
        tick();
        check("s3_pulse_one_cycle", 32'(loss_pulse), 32'd0);
        wait_release(60, e);
        check("s3_release_offset", 32'(e - base), 32'd24);
        check("s3_pulse_total", 32'(pulses), 32'd1);

        // Scenario 4: saturation and clear behaviour
        for (int i = 0; i < 16; i++) loss_event(1'b0, cnt_after);
        check("s4_saturated", 32'(loss_count), 32'd15);
        check("s4_pulse_total", 32'(pulses), 32'd17);
        loss_event(1'b1, cnt_after);
        check("s4_clear_with_loss", 32'(cnt_after), 32'd1);
        for (int i = 0; i < 14; i++) loss_event(1'b0, cnt_after);
        check("s4_resaturated", 32'(loss_count), 32'd15);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        check("s4_clear_at_sat", 32'(loss_count), 32'd0);
        check("s4_clear_keeps_run", 32'(sys_rst_n), 32'd1);
        loss_event(1'b0, cnt_after);
        check("s4_count_after_clear", 32'(cnt_after), 32'd1);

`ifdef HEARTBEAT_EN
        // Scenario 6: heartbeat toggles every HB_DIV cycles after entering RUN
        repeat (4) tick();
        check("s6_hb_before_first", 32'(heartbeat), 32'd0);
        tick();
        check("s6_hb_first_toggle", 32'(heartbeat), 32'd1);
        repeat (4) tick();
        check("s6_hb_hold_high", 32'(heartbeat), 32'd1);
        tick();
        check("s6_hb_second_toggle", 32'(heartbeat), 32'd0);
        repeat (5) tick();
        check("s6_hb_third_toggle", 32'(heartbeat), 32'd1);
`endif

        // Scenario 5: one-cycle reset while in RUN, then identical restart
        rst_n = 1'b0;
        tick();
        check("s5_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("s5_loss_count", 32'(loss_count), 32'd0);
        check("s5_heartbeat", 32'(heartbeat), 32'd0);
        check("s5_loss_pulse", 32'(loss_pulse), 32'd0);
        rst_n = 1'b1;
        cyc   = 0;
        repeat (18) tick();
        check("s5_held_edge18", 32'(sys_rst_n), 32'd0);
        tick();
        check("s5_release_edge19", 32'(sys_rst_n), 32'd1);

`ifndef HEARTBEAT_EN
        check("s6_heartbeat_never_high", 32'(hb_seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
